// File: rtl/pe_param_demux_router_pkg.sv
// Shared defaults for PE datapath blocks.
// Data and counter widths used when a parameter is not overridden.
package pe_param_demux_router_pkg;

    localparam int PE_DATA_W = 8;
    localparam int PE_CNT_W  = 8;

endpackage

// File: rtl/pe_param_demux_router_out_slot.sv
// One-entry output register slice for a demux channel.
// Load wins over drain so a slot can refill in the cycle it empties.
module pe_out_slot
    import pe_param_demux_router_pkg::*;
#(
    parameter int WIDTH = PE_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] d,
    output logic             full,
    output logic [WIDTH-1:0] q
);

    // slot state: load takes priority, otherwise drain empties it
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            q    <= '0;
        end else if (load) begin
            full <= 1'b1;
            q    <= d;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/pe_param_demux_router.sv
// Registered 1-to-N_OUT router with broadcast and drop counting.
// Select decode and ready reduction here; buffering lives in pe_out_slot.
module pe_param_demux_router
    import pe_param_demux_router_pkg::*;
#(
    parameter  int WIDTH = PE_DATA_W,
    parameter  int N_OUT = 2,
    parameter  int CNT_W = PE_CNT_W,
    localparam int SEL_W = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_bcast,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic                   sel_err,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam logic [SEL_W:0] N_X = (SEL_W+1)'(N_OUT);

    logic [N_OUT-1:0] full;
    logic [N_OUT-1:0] acc;
    logic [N_OUT-1:0] tgt;
    logic [N_OUT-1:0] load;
    logic             sel_oob;
    logic             xfer;
    logic             drop;

    // target set, ready reduction over targets, and per-slot load strobes
    always_comb begin
        acc     = ~full | out_ready;
        sel_oob = {1'b0, in_sel} >= N_X;
        tgt     = '0;
        for (int i = 0; i < N_OUT; i++) begin
            tgt[i] = in_bcast || (in_sel == SEL_W'(i));
        end
        in_ready = &(acc | ~tgt);
        xfer     = in_valid && in_ready;
        load     = xfer ? tgt : '0;
        drop     = xfer && !in_bcast && sel_oob;
    end

    // sticky select error and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err  <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            sel_err <= 1'b1;
            if (drop_cnt != {CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        pe_out_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load[g]),
            .drain (out_ready[g]),
            .d     (in_data),
            .full  (full[g]),
            .q     (out_data[g*WIDTH +: WIDTH])
        );
    end

    assign out_valid = full;

endmodule

// File: tb/tb_pe_param_demux_router.sv
// Testbench for pe_param_demux_router in 2-, 3- and 4-channel builds.
// Vector table, directed corner sequences, and a randomized model run.
module tb_pe_param_demux_router;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // N_OUT=2
    logic        v2, b2, ir2, err2;
    logic [0:0]  s2;
    logic [7:0]  d2, dc2;
    logic [1:0]  r2, ov2;
    logic [15:0] od2;
    // N_OUT=4
    logic        v4, b4, ir4, err4;
    logic [1:0]  s4;
    logic [7:0]  d4, dc4;
    logic [3:0]  r4, ov4;
    logic [31:0] od4;
    // N_OUT=3
    logic        v3, b3, ir3, err3;
    logic [1:0]  s3;
    logic [7:0]  d3, dc3;
    logic [2:0]  r3, ov3;
    logic [23:0] od3;
    // N_OUT=3, CNT_W=2
    logic        v3s, b3s, ir3s, err3s;
    logic [1:0]  s3s, dc3s;
    logic [7:0]  d3s;
    logic [2:0]  r3s, ov3s;
    logic [23:0] od3s;

    pe_param_demux_router #(.WIDTH(8), .N_OUT(2), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .in_data(d2), .in_sel(s2), .in_bcast(b2),
        .in_valid(v2), .in_ready(ir2), .out_data(od2), .out_valid(ov2),
        .out_ready(r2), .sel_err(err2), .drop_cnt(dc2)
    );
    pe_param_demux_router #(.WIDTH(8), .N_OUT(4), .CNT_W(8)) u4 (
        .clk(clk), .rst(rst), .in_data(d4), .in_sel(s4), .in_bcast(b4),
        .in_valid(v4), .in_ready(ir4), .out_data(od4), .out_valid(ov4),
        .out_ready(r4), .sel_err(err4), .drop_cnt(dc4)
    );
    pe_param_demux_router #(.WIDTH(8), .N_OUT(3), .CNT_W(8)) u3 (
        .clk(clk), .rst(rst), .in_data(d3), .in_sel(s3), .in_bcast(b3),
        .in_valid(v3), .in_ready(ir3), .out_data(od3), .out_valid(ov3),
        .out_ready(r3), .sel_err(err3), .drop_cnt(dc3)
    );
    pe_param_demux_router #(.WIDTH(8), .N_OUT(3), .CNT_W(2)) u3s (
        .clk(clk), .rst(rst), .in_data(d3s), .in_sel(s3s), .in_bcast(b3s),
        .in_valid(v3s), .in_ready(ir3s), .out_data(od3s), .out_valid(ov3s),
        .out_ready(r3s), .sel_err(err3s), .drop_cnt(dc3s)
    );

    typedef struct {
        logic       v;
        logic [0:0] s;
        logic       b;
        logic [7:0] d;
        logic [1:0] r;
        logic       er;
        logic [1:0] ev;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic v, logic s, logic b, logic [7:0] d,
                                logic [1:0] r, logic er, logic [1:0] ev,
                                logic [7:0] e0, logic [7:0] e1);
        vec_t t;
        t.v = v; t.s = s; t.b = b; t.d = d; t.r = r;
        t.er = er; t.ev = ev; t.e0 = e0; t.e1 = e1;
        return t;
    endfunction

    // reference model for the 3-channel build
    bit         mf[3];
    logic [7:0] md[3];
    bit         merr;
    int         mcnt;

    initial begin
        {v2, b2, s2, d2, r2} = '0;
        {v4, b4, s4, d4, r4} = '0;
        {v3, b3, s3, d3, r3} = '0;
        {v3s, b3s, s3s, d3s, r3s} = '0;

        tbl[0]  = mk(1, 1, 0, 8'hA5, 2'b11, 1, 2'b10, 8'h00, 8'hA5);
        tbl[1]  = mk(1, 0, 0, 8'h01, 2'b11, 1, 2'b01, 8'h01, 8'h00);
        tbl[2]  = mk(1, 0, 0, 8'h02, 2'b11, 1, 2'b01, 8'h02, 8'h00);
        tbl[3]  = mk(1, 1, 0, 8'h03, 2'b11, 1, 2'b10, 8'h00, 8'h03);
        tbl[4]  = mk(1, 0, 1, 8'h44, 2'b11, 1, 2'b11, 8'h44, 8'h44);
        tbl[5]  = mk(0, 0, 0, 8'h00, 2'b11, 1, 2'b00, 8'h00, 8'h00);
        tbl[6]  = mk(1, 0, 0, 8'h11, 2'b10, 1, 2'b01, 8'h11, 8'h00);
        tbl[7]  = mk(1, 0, 0, 8'h22, 2'b10, 0, 2'b01, 8'h11, 8'h00);
        tbl[8]  = mk(1, 0, 0, 8'h22, 2'b11, 1, 2'b01, 8'h22, 8'h00);
        tbl[9]  = mk(0, 0, 0, 8'h00, 2'b11, 1, 2'b00, 8'h00, 8'h00);
        tbl[10] = mk(1, 0, 0, 8'h55, 2'b00, 1, 2'b01, 8'h55, 8'h00);
        tbl[11] = mk(1, 1, 0, 8'h66, 2'b00, 1, 2'b11, 8'h55, 8'h66);
        tbl[12] = mk(1, 0, 1, 8'h77, 2'b01, 0, 2'b10, 8'h00, 8'h66);
        tbl[13] = mk(0, 0, 0, 8'h00, 2'b11, 1, 2'b00, 8'h00, 8'h00);

        repeat (2) tick();
        rst = 1'b0;

        // traffic, then a one-cycle reset
        v2 = 1'b1; s2 = 1'b1; d2 = 8'h5A; r2 = 2'b00;
        tick();
        #1;
        chk("pre_rst_valid", 32'(ov2), 32'h2);
        v2 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(ov2), 32'h0);
        chk("rst_data", 32'(od2), 32'h0);
        chk("rst_err", 32'(err2), 32'h0);
        chk("rst_cnt", 32'(dc2), 32'h0);
        chk("rst_ready", 32'(ir2), 32'h1);
        chk("rst_valid4", 32'(ov4), 32'h0);

        // vector table on the 2-channel build
        for (int k = 0; k < 14; k++) begin
            v2 = tbl[k].v; s2 = tbl[k].s; b2 = tbl[k].b;
            d2 = tbl[k].d; r2 = tbl[k].r;
            #1;
            chk($sformatf("tbl%0d_ready", k), 32'(ir2), 32'(tbl[k].er));
            tick();
            #1;
            chk($sformatf("tbl%0d_valid", k), 32'(ov2), 32'(tbl[k].ev));
            if (tbl[k].ev[0])
                chk($sformatf("tbl%0d_d0", k), 32'(od2[7:0]), 32'(tbl[k].e0));
            if (tbl[k].ev[1])
                chk($sformatf("tbl%0d_d1", k), 32'(od2[15:8]), 32'(tbl[k].e1));
        end
        v2 = 1'b0; b2 = 1'b0;

        // broadcast blocked by one stalled channel
        v4 = 1'b1; s4 = 2'd2; d4 = 8'h77; r4 = 4'b1111;
        tick();
        b4 = 1'b1; d4 = 8'h3C; r4 = 4'b1011;
        #1;
        chk("bc_stall_ready", 32'(ir4), 32'h0);
        tick();
        #1;
        chk("bc_stall_valid", 32'(ov4), 32'h4);
        chk("bc_stall_d2", 32'(od4[23:16]), 32'h77);
        r4 = 4'b1111;
        #1;
        chk("bc_rel_ready", 32'(ir4), 32'h1);
        tick();
        v4 = 1'b0; b4 = 1'b0;
        #1;
        chk("bc_all_valid", 32'(ov4), 32'hF);
        chk("bc_all_data", od4, 32'h3C3C3C3C);
        tick();
        #1;
        chk("bc_drained", 32'(ov4), 32'h0);

        // out-of-range select drops
        v3 = 1'b1; s3 = 2'd3; r3 = 3'b111;
        v3s = 1'b1; s3s = 2'd3; r3s = 3'b111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("oob_ready", 32'(ir3), 32'h1);
            chk("oob_ready_s", 32'(ir3s), 32'h1);
            tick();
        end
        v3 = 1'b0;
        #1;
        chk("oob_valid", 32'(ov3), 32'h0);
        chk("oob_err", 32'(err3), 32'h1);
        chk("oob_cnt", 32'(dc3), 32'h3);
        chk("oob_cnt_s3", 32'(dc3s), 32'h3);
        repeat (2) tick();
        v3s = 1'b0;
        #1;
        chk("sat_cnt", 32'(dc3s), 32'h3);
        chk("sat_err", 32'(err3s), 32'h1);
        chk("sat_valid", 32'(ov3s), 32'h0);

        // reset while slots are full and stalled
        v2 = 1'b1; b2 = 1'b1; d2 = 8'h99; r2 = 2'b00;
        tick();
        v2 = 1'b0; b2 = 1'b0;
        #1;
        chk("stall_full", 32'(ov2), 32'h3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("stall_rst_valid", 32'(ov2), 32'h0);
        chk("stall_rst_err3", 32'(err3), 32'h0);
        chk("stall_rst_cnt3", 32'(dc3), 32'h0);
        r2 = 2'b11;
        repeat (3) tick();
        #1;
        chk("stall_no_emit", 32'(ov2), 32'h0);

        // randomized traffic on the 3-channel build
        for (int i = 0; i < 3; i++) begin
            mf[i] = 1'b0;
            md[i] = 8'h00;
        end
        merr = 1'b0;
        mcnt = 0;
        for (int n = 0; n < 400; n++) begin
            bit ok;
            v3 = ($urandom_range(0, 3) != 0);
            s3 = 2'($urandom_range(0, 3));
            b3 = ($urandom_range(0, 4) == 0);
            d3 = 8'($urandom);
            r3 = 3'($urandom_range(0, 7));
            #1;
            chk("rnd_valid", 32'(ov3), 32'({mf[2], mf[1], mf[0]}));
            for (int i = 0; i < 3; i++) begin
                if (mf[i])
                    chk($sformatf("rnd_d%0d", i), 32'(od3[i*8 +: 8]), 32'(md[i]));
            end
            chk("rnd_err", 32'(err3), 32'(merr));
            chk("rnd_cnt", 32'(dc3), 32'(mcnt));
            ok = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if ((b3 || s3 == i) && mf[i] && !r3[i]) ok = 1'b0;
            end
            chk("rnd_ready", 32'(ir3), 32'(ok));
            for (int i = 0; i < 3; i++) begin
                if (v3 && ok && (b3 || s3 == i)) begin
                    mf[i] = 1'b1;
                    md[i] = d3;
                end else if (mf[i] && r3[i]) begin
                    mf[i] = 1'b0;
                end
            end
            if (v3 && ok && !b3 && s3 >= 3) begin
                merr = 1'b1;
                if (mcnt < 255) mcnt++;
            end
            tick();
        end
        v3 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
